sram_bridge: RTL and testbench

//  Memory-side responder for the CPU RAM bus (RAMaddr/RAMin/RAMout/we/re/be).

---
 rtl/sram_bridge.sv | 173 +++++++++++++++++
 tb/tb_sram_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
// sram_bridge: responder for the CPU RAM bus that turns each word or byte
// request into one or two timed byte cycles on an asynchronous 8-bit SRAM.
// Each byte phase runs ADDR -> STROBE (WAIT_CYCLES) -> RECOV. A word access
// runs two phases (even byte, then odd byte), and each access ends with a
// one-cycle DONE that pulses rdy.
module sram_bridge #(
    parameter int ADDR_W      = 19,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    input  logic              we,
    input  logic              re,
    input  logic              be,
    output logic [15:0]       rdata,
    output logic              rdy,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_RECOV,
        S_DONE
    } state_t;

    // The strobe counter is loaded with WAIT_CYCLES-1 and counts down to zero.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;      // even address for words, raw address for bytes
    logic [15:0]       wdata_q, wdata_d;
    logic              byte_q, byte_d;      // 1 = single-byte access
    logic              wr_q, wr_d;          // 1 = write, 0 = read
    logic              phase_q, phase_d;    // 0 = even/only byte, 1 = odd byte of a word
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        cap_lo_q, cap_lo_d;  // byte read during phase 0
    logic [7:0]        cap_hi_q, cap_hi_d;  // byte read during phase 1
    logic [15:0]       rdata_q, rdata_d;

    // State register and all datapath flops; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            byte_q   <= 1'b0;
            wr_q     <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            cap_lo_q <= '0;
            cap_hi_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            byte_q   <= byte_d;
            wr_q     <= wr_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            cap_lo_q <= cap_lo_d;
            cap_hi_q <= cap_hi_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state logic: sequence the byte phases and capture read data.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        byte_d   = byte_q;
        wr_d     = wr_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        cap_lo_d = cap_lo_q;
        cap_hi_d = cap_hi_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                // Requests are only looked at here; we wins over re.
                if (we || re) begin
                    addr_d  = be ? addr : {addr[ADDR_W-1:1], 1'b0};
                    wdata_d = wdata;
                    byte_d  = be;
                    wr_d    = we;
                    phase_d = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = CNT_LOAD;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Sample the SRAM at the edge that ends the strobe.
                    if (!wr_q) begin
                        if (phase_q) begin
                            cap_hi_d = sram_dq_in;
                        end else begin
                            cap_lo_d = sram_dq_in;
                        end
                    end
                    state_d = S_RECOV;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RECOV: begin
                if (!byte_q && !phase_q) begin
                    phase_d = 1'b1;
                    state_d = S_ADDR;
                end else begin
                    // rdata changes only on the edge into DONE of a read.
                    if (!wr_q) begin
                        rdata_d = byte_q ? {8'h00, cap_lo_q} : {cap_hi_q, cap_lo_q};
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM control decode: chip enabled through ADDR/STROBE/RECOV, pads driven
    // only for writes, so the SRAM output and the bridge never fight.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        unique case (state_q)
            S_ADDR, S_RECOV: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = wr_q;
            end
            S_STROBE: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = wr_q;
                sram_we_n  = ~wr_q;
                sram_oe_n  = wr_q;
            end
            default: begin
                sram_ce_n  = 1'b1;
            end
        endcase
    end

    // Phase 1 sets bit 0 of the even address, so it can never carry.
    assign sram_addr   = {addr_q[ADDR_W-1:1], addr_q[0] | phase_q};
    assign sram_dq_out = phase_q ? wdata_q[15:8] : wdata_q[7:0];
    assign rdata       = rdata_q;
    assign rdy         = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed vectors against two bridges (WAIT_CYCLES=1 and 3),
// each connected to a behavioural 512K x 8 asynchronous SRAM.
module tb_sram_bridge;

    localparam int AW = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Bridge with WAIT_CYCLES = 1
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          we, re, be;
    logic [15:0]   rdata;
    logic          rdy, busy;
    logic [AW-1:0] sram_addr;
    logic [7:0]    dq_out, dq_in;
    logic          dq_oe, ce_n, oe_n, we_n;

    // Bridge with WAIT_CYCLES = 3
    logic [AW-1:0] addr3;
    logic [15:0]   wdata3;
    logic          we3, re3, be3;
    logic [15:0]   rdata3;
    logic          rdy3, busy3;
    logic [AW-1:0] sram_addr3;
    logic [7:0]    dq_out3, dq_in3;
    logic          dq_oe3, ce3_n, oe3_n, we3_n;

    sram_bridge #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset),
        .addr(addr), .wdata(wdata), .we(we), .re(re), .be(be),
        .rdata(rdata), .rdy(rdy), .busy(busy),
        .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
        .sram_dq_oe(dq_oe), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
    );

    sram_bridge #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .addr(addr3), .wdata(wdata3), .we(we3), .re(re3), .be(be3),
        .rdata(rdata3), .rdy(rdy3), .busy(busy3),
        .sram_addr(sram_addr3), .sram_dq_out(dq_out3), .sram_dq_in(dq_in3),
        .sram_dq_oe(dq_oe3), .sram_ce_n(ce3_n), .sram_oe_n(oe3_n), .sram_we_n(we3_n)
    );

    // Behavioural SRAMs
    logic [7:0] mem  [0:(1<<AW)-1];
    logic [7:0] mem3 [0:(1<<AW)-1];

    assign dq_in  = (!ce_n  && !oe_n)  ? mem[sram_addr]   : 8'h00;
    assign dq_in3 = (!ce3_n && !oe3_n) ? mem3[sram_addr3] : 8'h00;

    // Bus monitors
    int n_vec = 0;
    int n_err = 0;
    int we_pulses, oe_pulses, we_low, proto_err, rdy_cnt;
    int oe3_pulses, oe3_run, proto3_err;
    int oe3_runs[$];
    logic [AW-1:0] wr_addrs[$];
    logic [AW-1:0] rd_addrs[$];
    logic [7:0]    wr_bytes[$];
    logic we_prev = 1'b1, oe_prev = 1'b1, oe3_prev = 1'b1;

    always @(negedge clk) begin
        if (!ce_n && !we_n && dq_oe) mem[sram_addr] = dq_out;
        if (!we_n && !oe_n) proto_err++;
        if (dq_oe && !oe_n) proto_err++;
        if ((!we_n || !oe_n) && ce_n) proto_err++;
        if (!we_n && we_prev) begin
            we_pulses++;
            wr_addrs.push_back(sram_addr);
            wr_bytes.push_back(dq_out);
        end
        if (!oe_n && oe_prev) begin
            oe_pulses++;
            rd_addrs.push_back(sram_addr);
        end
        if (!we_n) we_low++;
        if (rdy) rdy_cnt++;
        we_prev = we_n;
        oe_prev = oe_n;
    end

    always @(negedge clk) begin
        if (!we3_n) proto3_err++;
        if (dq_oe3 && !oe3_n) proto3_err++;
        if (!oe3_n && oe3_prev) oe3_pulses++;
        if (!oe3_n) begin
            oe3_run++;
        end else if (oe3_run > 0) begin
            oe3_runs.push_back(oe3_run);
            oe3_run = 0;
        end
        oe3_prev = oe3_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        we_pulses = 0;
        oe_pulses = 0;
        we_low    = 0;
        rdy_cnt   = 0;
        wr_addrs.delete();
        rd_addrs.delete();
        wr_bytes.delete();
    endtask

    // One access on the WAIT_CYCLES=1 bridge. Called just after a falling
    // edge; returns just after the falling edge following the rdy cycle.
    task automatic access(input string tag, input logic w, input logic r, input logic b,
                          input logic [AW-1:0] a, input logic [15:0] d, input bit toggle_re,
                          output int lat, output logic busy1);
        we = w; re = r; be = b; addr = a; wdata = d;
        lat = 0;
        busy1 = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) busy1 = busy;
            if (rdy) begin
                lat = i;
                break;
            end
            if (toggle_re) re = ~re;
        end
        we = 1'b0;
        re = 1'b0;
        $display("txn %s: addr=0x%05h wdata=0x%04h we=%0b re=%0b be=%0b -> latency=%0d rdata=0x%04h",
                 tag, a, d, w, r, b, lat, rdata);
        @(negedge clk);
        check({tag, "_rdy_single"}, {31'd0, rdy}, 32'd0);
        check({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic b1;

        reset = 1'b1;
        we = 0; re = 0; be = 0; addr = '0; wdata = '0;
        we3 = 0; re3 = 0; be3 = 0; addr3 = '0; wdata3 = '0;
        proto_err = 0; proto3_err = 0;
        oe3_pulses = 0; oe3_run = 0;
        clear_mon();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_rdy_busy", {30'd0, rdy, busy}, 32'd0);
        check("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_sram_addr", {13'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {24'd0, dq_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1. Word write 0xBEEF at 0x00100
        clear_mon();
        access("t1_word_wr", 1, 0, 0, 19'h00100, 16'hBEEF, 0, lat, b1);
        check("t1_latency", lat, 7);
        check("t1_busy_at_accept", {31'd0, b1}, 32'd1);
        check("t1_we_pulses", we_pulses, 2);
        check("t1_we_low_cycles", we_low, 2);
        check("t1_oe_pulses", oe_pulses, 0);
        check("t1_wr_addr0", {13'd0, wr_addrs[0]}, 32'h00100);
        check("t1_wr_addr1", {13'd0, wr_addrs[1]}, 32'h00101);
        check("t1_mem_100", {24'd0, mem[19'h00100]}, 32'hEF);
        check("t1_mem_101", {24'd0, mem[19'h00101]}, 32'hBE);
        check("t1_rdata_kept", {16'd0, rdata}, 32'd0);

        // 2. Word read at odd 0x00101 reads the 0x00100/0x00101 pair
        clear_mon();
        access("t2_word_rd", 0, 1, 0, 19'h00101, 16'h0000, 0, lat, b1);
        check("t2_latency", lat, 7);
        check("t2_rdata", {16'd0, rdata}, 32'hBEEF);
        check("t2_oe_pulses", oe_pulses, 2);
        check("t2_we_pulses", we_pulses, 0);
        check("t2_rd_addr0", {13'd0, rd_addrs[0]}, 32'h00100);
        check("t2_rd_addr1", {13'd0, rd_addrs[1]}, 32'h00101);

        // 3. Byte read at 0x00101, then byte write 0x1234 at 0x00003
        clear_mon();
        access("t3_byte_rd", 0, 1, 1, 19'h00101, 16'h0000, 0, lat, b1);
        check("t3_rd_latency", lat, 4);
        check("t3_rdata", {16'd0, rdata}, 32'h00BE);
        check("t3_oe_pulses", oe_pulses, 1);
        check("t3_rd_addr", {13'd0, rd_addrs[0]}, 32'h00101);
        mem[19'h00002] = 8'h11;
        mem[19'h00003] = 8'h22;
        mem[19'h00004] = 8'h33;
        clear_mon();
        access("t3_byte_wr", 1, 0, 1, 19'h00003, 16'h1234, 0, lat, b1);
        check("t3_wr_latency", lat, 4);
        check("t3_we_pulses", we_pulses, 1);
        check("t3_mem_003", {24'd0, mem[19'h00003]}, 32'h34);
        check("t3_mem_002", {24'd0, mem[19'h00002]}, 32'h11);
        check("t3_mem_004", {24'd0, mem[19'h00004]}, 32'h33);
        check("t3_rdata_kept", {16'd0, rdata}, 32'h00BE);

        // 4. we and re together at the top of memory, re toggling while busy
        clear_mon();
        access("t4_we_re", 1, 1, 0, 19'h7FFFE, 16'hA55A, 1, lat, b1);
        repeat (3) @(negedge clk);
        check("t4_latency", lat, 7);
        check("t4_we_pulses", we_pulses, 2);
        check("t4_oe_pulses", oe_pulses, 0);
        check("t4_wr_byte0", {24'd0, wr_bytes[0]}, 32'h5A);
        check("t4_wr_byte1", {24'd0, wr_bytes[1]}, 32'hA5);
        check("t4_mem_7fffe", {24'd0, mem[19'h7FFFE]}, 32'h5A);
        check("t4_mem_7ffff", {24'd0, mem[19'h7FFFF]}, 32'hA5);
        clear_mon();
        access("t4_word_rd_top", 0, 1, 0, 19'h7FFFF, 16'h0000, 0, lat, b1);
        check("t4_rd_rdata", {16'd0, rdata}, 32'hA55A);
        check("t4_rd_addr0", {13'd0, rd_addrs[0]}, 32'h7FFFE);
        check("t4_rd_addr1", {13'd0, rd_addrs[1]}, 32'h7FFFF);

        // 5. Reset during the phase-1 strobe of a word write
        clear_mon();
        mem[19'h00200] = 8'h00;
        we = 1; re = 0; be = 0; addr = 19'h00200; wdata = 16'h7788;
        @(posedge clk);
        repeat (5) @(negedge clk);
        check("t5_in_strobe_ph1", {31'd0, we_n}, 32'd0);
        check("t5_addr_ph1", {13'd0, sram_addr}, 32'h00201);
        reset = 1'b1;
        we = 1'b0;
        @(negedge clk);
        $display("txn t5_reset_abort: addr=0x00200 wdata=0x7788 aborted in phase 1 strobe");
        check("t5_strobes_high", {29'd0, ce_n, oe_n, we_n}, 32'h7);
        check("t5_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_no_rdy", rdy_cnt, 0);
        check("t5_mem_200", {24'd0, mem[19'h00200]}, 32'h88);
        access("t5_after_reset", 0, 1, 1, 19'h00200, 16'h0000, 0, lat, b1);
        check("t5_next_latency", lat, 4);
        check("t5_next_rdata", {16'd0, rdata}, 32'h0088);
        check("t5_protocol", proto_err, 0);

        // 6. WAIT_CYCLES=3 word read
        mem3[19'h00040] = 8'h11;
        mem3[19'h00041] = 8'h22;
        oe3_pulses = 0;
        oe3_runs.delete();
        re3 = 1; be3 = 0; addr3 = 19'h00041;
        lat = 0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rdy3) begin
                lat = i;
                break;
            end
        end
        re3 = 1'b0;
        $display("txn t6_wait3_word_rd: addr=0x00041 -> latency=%0d rdata=0x%04h", lat, rdata3);
        check("t6_latency", lat, 11);
        check("t6_rdata", {16'd0, rdata3}, 32'h2211);
        check("t6_oe_pulses", oe3_pulses, 2);
        check("t6_oe_run0", oe3_runs.size() > 0 ? oe3_runs[0] : 0, 3);
        check("t6_oe_run1", oe3_runs.size() > 1 ? oe3_runs[1] : 0, 3);
        @(negedge clk);
        check("t6_busy_clear", {31'd0, busy3}, 32'd0);
        check("t6_dq_idle", {23'd0, dq_oe3, dq_out3}, 32'd0);
        check("t6_protocol", proto3_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
